// File: rtl/mem_read_sequencer_pkg.sv
// Shared state encoding and buffer sizing for the memory read sequencer.
package mem_read_sequencer_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mem_read_sequencer_fifo.sv
// Small skid FIFO for returned read data; head is presented straight from storage.
module rd_skid_fifo
  import mem_read_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic [FIFO_CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, rptr_q, wptr_nxt, rptr_nxt;
  logic [FIFO_CNT_W-1:0] cnt_q;
  logic                  do_push, do_pop;

  assign do_pop   = pop_i && (cnt_q != '0);
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push  = push_i && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
  assign wptr_nxt = (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
  assign rptr_nxt = (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_nxt;
      end
      if (do_pop) rptr_q <= rptr_nxt;
      cnt_q <= cnt_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/mem_read_sequencer.sv
// Streams a contiguous block of RAM words to a valid/ready consumer.
// Reads are credit-limited so the 2-entry return FIFO can never overflow.
module mem_read_sequencer
  import mem_read_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRdEn,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy,
  output logic                  done
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q;
  logic                  issue, flush, pop, push, credit;
  logic [FIFO_CNT_W-1:0] fifo_cnt;

  assign pop    = outValid & outReady;
  // Room for one more word once everything already owed to the FIFO has landed.
  assign credit = (int'(fifo_cnt) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
  // A returning word is dropped when the transfer is cancelled under it.
  assign push   = inflight_q & ~flush;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = baseAddr;
          rem_d   = length;
          state_d = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if ((rem_q != '0) && credit) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (!inflight_q && ((int'(fifo_cnt) - int'(pop)) == 0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        flush   = abort;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
    end
  end

  // Strobe decodes registered state; outReady only enters through the credit check.
  assign memRdEn = issue;
  assign memAddr = addr_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);

  rd_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (memData),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (outData),
    .valid_o     (outValid),
    .count_o     (fifo_cnt)
  );
endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: table vectors, abort/reset sequences, random transfers.
module tb_mem_read_sequencer;
  localparam int AW = 12, DW = 12, LW = 12;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, outReady = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [LW-1:0] length = '0;
  logic [AW-1:0] memAddr;
  logic          memRdEn, outValid, busy, done;
  logic [DW-1:0] memData = '0, outData;

  mem_read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .length(length),
    .abort(abort), .memAddr(memAddr), .memRdEn(memRdEn), .memData(memData),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int ncomp = 0, nfail = 0;
  int cyc = 0, t0 = 0;
  logic [DW-1:0] key = '0;
  logic mon_en = 1'b0;
  int aq[$], acq[$], dq[$], dcq[$], doneq[$];
  int busy_seen = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [DW-1:0] pd = '0;

  typedef struct {
    logic [AW-1:0] base;
    int len; int mode; int rlo; int rhi; bit inj;
    int exp_done; int exp_lhs; int exp_rd8;
  } vec_t;

  function automatic logic [DW-1:0] ramv(input logic [AW-1:0] a);
    return DW'(a) ^ key;
  endfunction

  function automatic logic rdy(input int mode, input int rel, input int lo, input int hi);
    if (mode == 1) return !(rel >= lo && rel <= hi);
    if (mode == 2) return $urandom_range(0, 2) != 0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncomp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (memRdEn) memData <= ramv(memAddr);

  always @(negedge clk) begin
    if (mon_en) begin
      if (memRdEn) begin aq.push_back(int'(memAddr)); acq.push_back(cyc - t0); end
      if (outValid && outReady) begin dq.push_back(int'(outData)); dcq.push_back(cyc - t0); end
      if (done) doneq.push_back(cyc - t0);
      if (busy) busy_seen++;
    end
    if (outValid && pv && !pr) chk("hold_stable", int'(outData), int'(pd));
    pv <= outValid;
    pr <= outReady;
    pd <= outData;
  end

  task automatic clear_mon();
    aq.delete(); acq.delete(); dq.delete(); dcq.delete(); doneq.delete();
    busy_seen = 0;
  endtask

  task automatic run_xfer(input string nm, input vec_t v);
    int rel, n, nrd8;
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; mon_en = 1'b1; rel = 0;
    start = 1'b1; baseAddr = v.base; length = LW'(v.len);
    outReady = rdy(v.mode, 0, v.rlo, v.rhi);
    @(negedge clk); #1;
    while (doneq.size() == 0 && rel < 200) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = 1'b0;
      if (v.inj && busy && $urandom_range(0, 2) == 0) begin
        start = 1'b1; baseAddr = AW'($urandom); length = LW'($urandom_range(0, 20));
      end
      outReady = rdy(v.mode, rel, v.rlo, v.rhi);
      @(negedge clk); #1;
    end
    if (doneq.size() == 0) chk({nm, "_timeout"}, 0, 1);
    @(posedge clk); #1; start = 1'b0; outReady = 1'b1;
    @(negedge clk); #1; mon_en = 1'b0;

    chk({nm, "_nreads"}, aq.size(), v.len);
    n = (aq.size() < v.len) ? aq.size() : v.len;
    for (int i = 0; i < n; i++) chk({nm, "_addr"}, aq[i], int'(AW'(v.base + AW'(i))));
    chk({nm, "_nwords"}, dq.size(), v.len);
    n = (dq.size() < v.len) ? dq.size() : v.len;
    for (int i = 0; i < n; i++) chk({nm, "_data"}, dq[i], int'(ramv(AW'(v.base + AW'(i)))));
    chk({nm, "_ndone"}, doneq.size(), 1);
    if (v.exp_done >= 0 && doneq.size() > 0) chk({nm, "_done_cyc"}, doneq[0], v.exp_done);
    if (v.exp_lhs >= 0 && dcq.size() > 0) chk({nm, "_last_hs"}, dcq[$], v.exp_lhs);
    if (v.exp_rd8 >= 0) begin
      nrd8 = 0;
      foreach (acq[i]) if (acq[i] <= 8) nrd8++;
      chk({nm, "_reads_le8"}, nrd8, v.exp_rd8);
    end
    if (v.mode == 0) begin
      for (int i = 0; i < acq.size(); i++) chk({nm, "_rd_cyc"}, acq[i], i + 1);
      for (int i = 0; i < dcq.size(); i++) chk({nm, "_hs_cyc"}, dcq[i], i + 3);
    end
    if (v.len == 0) chk({nm, "_busy_seen"}, busy_seen, 0);
    if (dcq.size() > 0 && doneq.size() > 0) chk({nm, "_done_after_hs"}, int'(doneq[0] > dcq[$]), 1);
  endtask

  initial begin
    vec_t vt[6];
    vec_t rv;
    vt[0] = '{12'h010, 4, 0, -1, -1, 1'b0, 7, 6, 4};
    vt[1] = '{12'h010, 4, 1, 3, 8, 1'b0, 13, 12, 2};
    vt[2] = '{12'hFFE, 4, 0, -1, -1, 1'b1, 7, 6, 4};
    vt[3] = '{12'h123, 0, 0, -1, -1, 1'b0, 1, -1, 0};
    vt[4] = '{12'h3F0, 1, 0, -1, -1, 1'b0, 4, 3, 1};
    vt[5] = '{12'h050, 2, 1, 3, 3, 1'b0, 6, 5, 2};

    #12;
    chk("rst_memAddr", int'(memAddr), 0);
    chk("rst_memRdEn", int'(memRdEn), 0);
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_outData", int'(outData), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1; rst = 1'b0;

    key = '0;
    foreach (vt[i]) run_xfer($sformatf("vec%0d", i), vt[i]);

    // Abort in cycle 3 of an 8-word transfer, then a short clean transfer.
    key = 12'h5A3;
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; mon_en = 1'b1;
    start = 1'b1; baseAddr = 12'h100; length = 12'd8; outReady = 1'b1;
    for (int rel = 1; rel <= 14; rel++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = (rel == 3); outReady = (rel <= 3);
      @(negedge clk); #1;
      if (rel == 3) chk("abort_rden", int'(memRdEn), 0);
      if (rel == 4) begin
        chk("abort_valid", int'(outValid), 0);
        chk("abort_busy", int'(busy), 0);
      end
    end
    abort = 1'b0; mon_en = 1'b0;
    chk("abort_nodone", doneq.size(), 0);
    chk("abort_reads", aq.size(), 2);
    rv = '{12'h200, 2, 0, -1, -1, 1'b0, 5, 4, 2};
    run_xfer("post_abort", rv);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    start = 1'b1; baseAddr = 12'h155; length = 12'd8; outReady = 1'b0;
    repeat (3) begin @(posedge clk); #1; start = 1'b0; end
    chk("mid_busy_pre", int'(busy), 1);
    rst = 1'b1; #1;
    chk("mid_rst_memAddr", int'(memAddr), 0);
    chk("mid_rst_memRdEn", int'(memRdEn), 0);
    chk("mid_rst_outValid", int'(outValid), 0);
    chk("mid_rst_outData", int'(outData), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    @(posedge clk); #1; rst = 1'b0;
    rv = '{12'h7F0, 3, 0, -1, -1, 1'b0, 6, 5, 3};
    run_xfer("post_rst", rv);

    // Random transfers against the spec-level stream model.
    for (int k = 0; k < 14; k++) begin
      key = DW'($urandom);
      rv.base = AW'($urandom);
      rv.len  = $urandom_range(0, 9);
      rv.mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      rv.rlo = -1; rv.rhi = -1; rv.inj = 1'b1;
      rv.exp_done = (rv.mode == 0) ? ((rv.len == 0) ? 1 : rv.len + 3) : -1;
      rv.exp_lhs  = (rv.mode == 0 && rv.len > 0) ? rv.len + 2 : -1;
      rv.exp_rd8  = -1;
      run_xfer($sformatf("rnd%0d", k), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
